bl_zone_scheduler: RTL and testbench

BL_ZONE_SCHEDULER -- requirements
Module: bl_zone_scheduler

---
 rtl/bl_pkg.sv | 32 +++
 rtl/bl_raster_cnt.sv | 53 +++++
 rtl/bl_zone_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_bl_zone_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bl_pkg : shared states, default zone geometry and widths for the         |
// |          backlight zone scheduler.                Revision: 1.0          |
// +--------------------------------------------------------------------------+
package bl_pkg;

    localparam int c_DEF_ZONE_W    = 64;
    localparam int c_DEF_ZONE_H    = 64;
    localparam int c_DEF_ZONE_COLS = 8;
    localparam int c_DEF_ZONE_ROWS = 4;

    localparam int c_PIX_W = 8;
    localparam int c_SW_W  = 4;
    localparam int c_IDX_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_CLEAR   = 3'd2,
        ST_ACCUM   = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_CAPTURE = 3'd5
    } state_t;

    // Counter width that never collapses to zero bits for tiny geometries.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bl_raster_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bl_raster_cnt : pixel (x) and line (y) position of the incoming raster.  |
// |                                                   Revision: 1.0          |
// +--------------------------------------------------------------------------+
module bl_raster_cnt #(
    parameter int X_W = 10,
    parameter int Y_W = 9
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           vs_i,
    input  logic           de_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o
);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           de_q;

    // Both counters saturate so oversized rasters never alias back into a zone.
    always_comb begin
        x_d = '0;
        if (de_i) begin
            x_d = (x_q == '1) ? x_q : x_q + 1'b1;
        end

        y_d = y_q;
        if (vs_i) begin
            y_d = '0;
        end else if (de_q && !de_i && (y_q != '1)) begin
            y_d = y_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q  <= '0;
            y_q  <= '0;
            de_q <= 1'b0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            de_q <= de_i;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

endmodule
`default_nettype wire

// File: rtl/bl_zone_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bl_zone_scheduler : time-shares one averaging datapath over all zones,   |
// |                     one zone per frame.               Revision: 1.0      |
// +--------------------------------------------------------------------------+
module bl_zone_scheduler
    import bl_pkg::*;
#(
    parameter int ZONE_W    = c_DEF_ZONE_W,
    parameter int ZONE_H    = c_DEF_ZONE_H,
    parameter int ZONE_COLS = c_DEF_ZONE_COLS,
    parameter int ZONE_ROWS = c_DEF_ZONE_ROWS
) (
    input  logic               iODCK,
    input  logic               iRST,
    input  logic               iEnable,
    input  logic               iVS,
    input  logic               iDE,
    input  logic [c_PIX_W-1:0] iPixelData,
    input  logic [c_SW_W-1:0]  iSw_0Max_1Avg,
    input  logic [c_PIX_W-1:0] iBlockData,
    input  logic               iZoneReady,
    output logic [c_PIX_W-1:0] oPixelData,
    output logic               oH_Duty,
    output logic               oV_Duty,
    output logic               oAvgRst,
    output logic [c_SW_W-1:0]  oSw,
    output logic               oZoneValid,
    output logic [c_IDX_W-1:0] oZoneIdx,
    output logic [c_PIX_W-1:0] oZoneData,
    output logic               oOverflow,
    output logic               oBusy
);

    localparam int c_X_W    = $clog2(ZONE_W * ZONE_COLS + 1);
    localparam int c_Y_W    = $clog2(ZONE_H * ZONE_ROWS + 1);
    localparam int c_COL_W  = clog2_min1(ZONE_COLS);
    localparam int c_ROW_W  = clog2_min1(ZONE_ROWS);
    localparam int c_NZONES = ZONE_COLS * ZONE_ROWS;

    state_t               state_q, state_d;
    logic [c_COL_W-1:0]   col_q, col_d;
    logic [c_ROW_W-1:0]   row_q, row_d;
    logic [c_IDX_W-1:0]   idx_q, idx_d;
    logic                 h_q, h_d;
    logic                 v_q, v_d;
    logic                 last_q, last_d;
    logic                 avg_rst_q, avg_rst_d;
    logic [c_SW_W-1:0]    sw_q, sw_d;
    logic [c_PIX_W-1:0]   pix_q;
    logic                 valid_q, valid_d;
    logic [c_IDX_W-1:0]   zidx_q, zidx_d;
    logic [c_PIX_W-1:0]   zdata_q, zdata_d;
    logic                 ovf_q, ovf_d;

    logic [c_X_W-1:0]     w_x, w_x_lo, w_x_hi;
    logic [c_Y_W-1:0]     w_y, w_y_lo, w_y_hi;
    logic                 w_in_x, w_in_y, w_row_first, w_last_pix;

    bl_raster_cnt #(
        .X_W (c_X_W),
        .Y_W (c_Y_W)
    ) u_raster (
        .clk_i  (iODCK),
        .rst_ni (iRST),
        .vs_i   (iVS),
        .de_i   (iDE),
        .x_o    (w_x),
        .y_o    (w_y)
    );

    assign w_x_lo      = c_X_W'(int'(col_q) * ZONE_W);
    assign w_x_hi      = w_x_lo + c_X_W'(ZONE_W - 1);
    assign w_y_lo      = c_Y_W'(int'(row_q) * ZONE_H);
    assign w_y_hi      = w_y_lo + c_Y_W'(ZONE_H - 1);
    assign w_in_x      = iDE && (w_x >= w_x_lo) && (w_x <= w_x_hi);
    assign w_in_y      = (w_y >= w_y_lo) && (w_y <= w_y_hi);
    assign w_row_first = iDE && (w_y == w_y_lo);
    assign w_last_pix  = w_in_x && (w_x == w_x_hi) && (w_y == w_y_hi);

    always_ff @(posedge iODCK or negedge iRST) begin
        if (!iRST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        h_d       = 1'b0;
        v_d       = 1'b0;
        last_d    = 1'b0;
        sw_d      = sw_q;
        col_d     = col_q;
        row_d     = row_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        zidx_d    = zidx_q;
        zdata_d   = zdata_q;
        ovf_d     = ovf_q;

        if (valid_q && iZoneReady) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (iEnable) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!iEnable) begin
                    state_d = ST_IDLE;
                end else if (iVS) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (iVS) begin
                    state_d = ST_CLEAR;
                end else if (last_q) begin
                    // Trailing V-only cycle that closes the final zone line.
                    state_d = ST_SETTLE;
                    v_d     = 1'b1;
                end else begin
                    h_d    = w_in_x && w_in_y;
                    v_d    = v_q || w_row_first;
                    last_d = w_last_pix;
                end
            end
            ST_SETTLE: begin
                state_d = iVS ? ST_CLEAR : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // A full holding slot drops the new result but still moves on.
                if (!valid_q || iZoneReady) begin
                    valid_d = 1'b1;
                    zidx_d  = idx_q;
                    zdata_d = iBlockData;
                end else begin
                    ovf_d = 1'b1;
                end

                if (idx_q == c_IDX_W'(c_NZONES - 1)) begin
                    idx_d = '0;
                    col_d = '0;
                    row_d = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                    if (col_q == c_COL_W'(ZONE_COLS - 1)) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                state_d = iEnable ? ST_ARM : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        avg_rst_d = (state_d != ST_CLEAR);
        if (state_d == ST_CLEAR) begin
            sw_d = iSw_0Max_1Avg;
        end
    end

    always_ff @(posedge iODCK or negedge iRST) begin
        if (!iRST) begin
            col_q     <= '0;
            row_q     <= '0;
            idx_q     <= '0;
            h_q       <= 1'b0;
            v_q       <= 1'b0;
            last_q    <= 1'b0;
            avg_rst_q <= 1'b0;
            sw_q      <= '0;
            pix_q     <= '0;
            valid_q   <= 1'b0;
            zidx_q    <= '0;
            zdata_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            idx_q     <= idx_d;
            h_q       <= h_d;
            v_q       <= v_d;
            last_q    <= last_d;
            avg_rst_q <= avg_rst_d;
            sw_q      <= sw_d;
            pix_q     <= iPixelData;
            valid_q   <= valid_d;
            zidx_q    <= zidx_d;
            zdata_q   <= zdata_d;
            ovf_q     <= ovf_d;
        end
    end

    assign oPixelData = pix_q;
    assign oH_Duty    = h_q;
    assign oV_Duty    = v_q;
    assign oAvgRst    = avg_rst_q;
    assign oSw        = sw_q;
    assign oZoneValid = valid_q;
    assign oZoneIdx   = zidx_q;
    assign oZoneData  = zdata_q;
    assign oOverflow  = ovf_q;
    assign oBusy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bl_zone_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bl_zone_scheduler : scoreboard bench with a small averaging-datapath  |
// |                        model on a 4x4-pixel zone grid. Revision: 1.0     |
// +--------------------------------------------------------------------------+
module tb_bl_zone_scheduler;

    localparam int ZW      = 4;
    localparam int ZH      = 4;
    localparam int ZC      = 8;
    localparam int ZR      = 4;
    localparam int FRAME_W = ZW * ZC;
    localparam int FRAME_H = ZH * ZR;
    localparam int H_BLANK = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       vs    = 1'b0;
    logic       de    = 1'b0;
    logic       ready = 1'b1;
    logic [7:0] pix   = 8'h00;
    logic [3:0] sw    = 4'd6;
    logic [7:0] blk;

    logic [7:0] oPixelData;
    logic       oH_Duty, oV_Duty, oAvgRst;
    logic [3:0] oSw;
    logic       oZoneValid;
    logic [4:0] oZoneIdx;
    logic [7:0] oZoneData;
    logic       oOverflow, oBusy;

    always #5 clk = ~clk;

    bl_zone_scheduler #(
        .ZONE_W    (ZW),
        .ZONE_H    (ZH),
        .ZONE_COLS (ZC),
        .ZONE_ROWS (ZR)
    ) dut (
        .iODCK         (clk),
        .iRST          (rst_n),
        .iEnable       (en),
        .iVS           (vs),
        .iDE           (de),
        .iPixelData    (pix),
        .iSw_0Max_1Avg (sw),
        .iBlockData    (blk),
        .iZoneReady    (ready),
        .oPixelData    (oPixelData),
        .oH_Duty       (oH_Duty),
        .oV_Duty       (oV_Duty),
        .oAvgRst       (oAvgRst),
        .oSw           (oSw),
        .oZoneValid    (oZoneValid),
        .oZoneIdx      (oZoneIdx),
        .oZoneData     (oZoneData),
        .oOverflow     (oOverflow),
        .oBusy         (oBusy)
    );

    // Datapath model: sums windowed pixels, result = sat8((sum << 6) >> (sw + 4)).
    int unsigned acc = 0;
    int unsigned scaled;
    always @(posedge clk) begin
        if (!oAvgRst)     acc <= 0;
        else if (oH_Duty) acc <= acc + int'(oPixelData);
    end
    always_comb begin
        scaled = (acc << 6) >> (int'(oSw) + 4);
        blk    = (scaled > 255) ? 8'hFF : scaled[7:0];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [4:0] idx;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t e_mon;

    task automatic push(input int idx, input int data);
        exp_t e;
        e.idx  = 5'(idx);
        e.data = 8'(data);
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted result is checked against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && oZoneValid && ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected result: idx %0d data 0x%0h, expected none", oZoneIdx, oZoneData);
            end else begin
                e_mon = exp_q.pop_front();
                chk("zone idx", int'(oZoneIdx), int'(e_mon.idx));
                chk("zone data", int'(oZoneData), int'(e_mon.data));
            end
        end
    end

    // oPixelData must trail iPixelData by exactly one clock.
    logic [7:0] pix_exp  = 8'h00;
    logic       pix_live = 1'b0;
    always @(posedge clk) begin
        pix_exp  <= pix;
        pix_live <= rst_n;
    end
    always @(negedge clk) begin
        if (rst_n && pix_live) chk("pixel delay", int'(oPixelData), int'(pix_exp));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [7:0] cval, input bit grad,
                             input int abort_line, input int en_drop_line);
        vs = 1'b1;
        step(1);
        vs = 1'b0;
        step(4);
        for (int y = 0; y < FRAME_H; y++) begin
            if (y == abort_line) return;
            if (y == en_drop_line) en = 1'b0;
            for (int x = 0; x < FRAME_W; x++) begin
                de  = 1'b1;
                pix = grad ? 8'(4 * x + y) : cval;
                step(1);
            end
            de  = 1'b0;
            pix = 8'h5A;
            step(H_BLANK);
        end
        step(H_BLANK);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " oPixelData"}, int'(oPixelData), 0);
        chk({tag, " oH_Duty"},    int'(oH_Duty),    0);
        chk({tag, " oV_Duty"},    int'(oV_Duty),    0);
        chk({tag, " oAvgRst"},    int'(oAvgRst),    0);
        chk({tag, " oSw"},        int'(oSw),        0);
        chk({tag, " oZoneValid"}, int'(oZoneValid), 0);
        chk({tag, " oZoneIdx"},   int'(oZoneIdx),   0);
        chk({tag, " oZoneData"},  int'(oZoneData),  0);
        chk({tag, " oOverflow"},  int'(oOverflow),  0);
        chk({tag, " oBusy"},      int'(oBusy),      0);
    endtask

    initial begin
        pix = 8'h33;
        step(2);
        check_reset_outputs("por");
        rst_n = 1'b1;
        step(2);
        en = 1'b1;
        step(2);

        // Zones 0,1: flat 0x80 with shift 6 averages back to 0x80.
        push(0, 8'h80); run_frame(8'h80, 1'b0, -1, -1);
        push(1, 8'h80); run_frame(8'h80, 1'b0, -1, -1);

        // Zone 2: shift 0 saturates; latched shift must not follow the input.
        sw = 4'd0;
        push(2, 8'hFF); run_frame(8'h80, 1'b0, -1, -1);
        chk("oSw latched 0", int'(oSw), 0);
        sw = 4'd6;
        step(1);
        chk("oSw holds until next frame", int'(oSw), 0);

        // Zone 3 on gradient 4x+y: x 12..15, y 0..3 -> sum 888 -> 0x37.
        push(3, 8'h37); run_frame(8'h00, 1'b1, -1, -1);
        chk("oSw relatched 6", int'(oSw), 6);

        for (int z = 4; z < ZC * ZR; z++) begin
            push(z, 8'h80);
            run_frame(8'h80, 1'b0, -1, -1);
        end
        push(0, 8'h80); run_frame(8'h80, 1'b0, -1, -1);
        chk("no overflow yet", int'(oOverflow), 0);

        // Stalled sink: zone 1 held, zone 2 dropped.
        ready = 1'b0;
        push(1, 8'h80);
        run_frame(8'h80, 1'b0, -1, -1);
        run_frame(8'h80, 1'b0, -1, -1);
        chk("overflow sticky", int'(oOverflow), 1);
        chk("held valid",      int'(oZoneValid), 1);
        chk("held idx",        int'(oZoneIdx), 1);
        chk("held data",       int'(oZoneData), 8'h80);
        ready = 1'b1;
        step(2);
        chk("valid cleared after accept", int'(oZoneValid), 0);

        // Abort zone 3 mid-zone with an early VS; the next full frame reports zone 3.
        run_frame(8'h80, 1'b0, 2, -1);
        push(3, 8'h37); run_frame(8'h00, 1'b1, -1, -1);

        // Reset in the middle of zone 4.
        run_frame(8'h80, 1'b0, 2, -1);
        chk("busy in accum", int'(oBusy), 1);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("mid-accum");
        step(3);
        rst_n = 1'b1;
        step(2);
        push(0, 8'h40); run_frame(8'h40, 1'b0, -1, -1);

        // Enable falls mid-zone: zone 1 still completes, then idle.
        push(1, 8'h40); run_frame(8'h40, 1'b0, -1, 1);
        chk("idle after enable drop", int'(oBusy), 0);
        run_frame(8'h40, 1'b0, -1, -1);
        chk("stays idle", int'(oBusy), 0);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step(1);
        chk("scoreboard drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
